// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: FSM state encoding and
// the ALU control codes produced by the ALU control stage.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_MUL = 4'hA;

endpackage

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for the EX stage. Produces the low WIDTH
// bits of src1*src2 after WIDTH BUSY cycles and stalls the pipeline while
// working.
// Optional feature: define MUL_EARLY_TERM_EN to leave BUSY as soon as the
// shifted multiplier has no remaining set bits.
module mul_unit
  import mul_pkg::*;
#(
  parameter int         WIDTH  = 32,
  parameter logic [3:0] MUL_OP = ALU_MUL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplr_q,   mplr_d;
  logic [WIDTH-1:0]   acc_q,    acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;

  logic               accept_s;
  logic               early_s;
  logic               last_s;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]   acc_sum_s;
  logic [WIDTH-1:0]   mplr_shift_s;

  // A start is taken only from IDLE with the multiply code; a flush vetoes it.
  assign accept_s     = (state_q == IDLE) && start_i && (ctrl_i == MUL_OP) && !flush_i;
  assign addend_s     = mplr_q[0] ? mcand_q : '0;
  assign acc_sum_s    = acc_q + addend_s;
  assign mplr_shift_s = mplr_q >> 1;

`ifdef MUL_EARLY_TERM_EN
  assign early_s = (mplr_shift_s == '0);
`else
  assign early_s = 1'b0;
`endif

  assign last_s = (cnt_q == CNT_LAST) || early_s;

  // Stall covers the accepting cycle and all of BUSY (whose final cycle precedes DONE).
  assign stall_o  = accept_s || (state_q == BUSY);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

  // Next-state and shift-add datapath decode.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          mcand_d = src1_i;
          mplr_d  = src2_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d   = acc_sum_s;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_shift_s;
        cnt_d   = cnt_q + CNT_ONE;
        if (flush_i) begin
          state_d = IDLE;
        end else if (last_s) begin
          result_d = acc_sum_s;
          state_d  = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
